// File: rtl/mutex_lock_engine.sv
// Lock-acquisition master for the hardware mutex: write {owner,value}, read it back, retry with fixed backoff.
// Moore outputs decoded from the state register; uncontended acquire reaches locked three cycles after acquire_req.
module mutex_lock_engine #(
  parameter logic [15:0] OWNER_ID       = 16'h0001,
  parameter logic [15:0] LOCK_VALUE     = 16'h0001,
  parameter int unsigned BACKOFF_CYCLES = 8,
  parameter int unsigned MAX_RETRIES    = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        acquire_req,
  input  logic        release_req,
  output logic        busy,
  output logic        locked,
  output logic        acq_fail,
  output logic        mtx_address,
  output logic        mtx_chipselect,
  output logic        mtx_read,
  output logic        mtx_write,
  output logic [31:0] mtx_writedata,
  input  logic [31:0] mtx_readdata
);

  localparam int unsigned RW = (MAX_RETRIES < 2) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam int unsigned BW = (BACKOFF_CYCLES <= 2) ? 1 : $clog2(BACKOFF_CYCLES);
  localparam logic [BW-1:0] BACKOFF_INIT = BW'(BACKOFF_CYCLES - 1);
  localparam logic [31:0]   LOCK_WORD    = {OWNER_ID, LOCK_VALUE};
  localparam logic [31:0]   UNLOCK_WORD  = {OWNER_ID, 16'h0000};

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD, S_BACKOFF, S_LOCKED, S_REL, S_FAIL
  } state_t;

  state_t        state, state_nxt;
  logic [RW-1:0] retry_cnt, retry_nxt;
  logic [BW-1:0] backoff_cnt, backoff_nxt;
  logic [31:0]   retry_inc;

  assign retry_inc = 32'(retry_cnt) + 32'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      retry_cnt   <= '0;
      backoff_cnt <= '0;
    end else begin
      state       <= state_nxt;
      retry_cnt   <= retry_nxt;
      backoff_cnt <= backoff_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    retry_nxt   = retry_cnt;
    backoff_nxt = backoff_cnt;
    case (state)
      S_IDLE: begin
        if (acquire_req) begin
          state_nxt = S_WR;
          retry_nxt = '0;
        end
      end
      S_WR: state_nxt = S_RD;
      S_RD: begin
        if (mtx_readdata == LOCK_WORD) begin
          state_nxt = S_LOCKED;
        end else begin
          // Saturate so an unbounded retry loop never wraps the counter.
          retry_nxt = (&retry_cnt) ? retry_cnt : retry_cnt + 1'b1;
          if (MAX_RETRIES != 0 && retry_inc == MAX_RETRIES) begin
            state_nxt = S_FAIL;
          end else begin
            state_nxt   = S_BACKOFF;
            backoff_nxt = BACKOFF_INIT;
          end
        end
      end
      S_BACKOFF: begin
        if (backoff_cnt == '0) begin
          state_nxt = acquire_req ? S_WR : S_IDLE;
        end else begin
          backoff_nxt = backoff_cnt - 1'b1;
        end
      end
      S_LOCKED: begin
        if (release_req) state_nxt = S_REL;
      end
      S_REL:   state_nxt = S_IDLE;
      S_FAIL:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy           = 1'b1;
    locked         = 1'b0;
    acq_fail       = 1'b0;
    mtx_address    = 1'b0;
    mtx_chipselect = 1'b0;
    mtx_read       = 1'b0;
    mtx_write      = 1'b0;
    mtx_writedata  = 32'h0;
    case (state)
      S_IDLE:   busy = 1'b0;
      S_WR: begin
        mtx_chipselect = 1'b1;
        mtx_write      = 1'b1;
        mtx_writedata  = LOCK_WORD;
      end
      S_RD: begin
        mtx_chipselect = 1'b1;
        mtx_read       = 1'b1;
      end
      S_LOCKED: begin
        busy   = 1'b0;
        locked = 1'b1;
      end
      S_REL: begin
        mtx_chipselect = 1'b1;
        mtx_write      = 1'b1;
        mtx_writedata  = UNLOCK_WORD;
      end
      S_FAIL:  acq_fail = 1'b1;
      default: busy = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mutex_lock_engine.sv
// Bench for mutex_lock_engine: behavioural mutex slave plus event monitor; timing expectations from the protocol rules.
module tb_mutex_lock_engine;

  localparam logic [15:0] OWNER      = 16'h0003;
  localparam int          MAXR       = 3;
  localparam int          BOFF       = 8;
  localparam int          ATTEMPT    = 2 + BOFF;
  localparam logic [31:0] OTHER_WORD = 32'h0002_0001;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        acquire_req = 1'b0;
  logic        release_req = 1'b0;
  logic        busy, locked, acq_fail;
  logic        mtx_address, mtx_chipselect, mtx_read, mtx_write;
  logic [31:0] mtx_writedata, mtx_readdata;

  mutex_lock_engine #(
    .OWNER_ID(OWNER), .LOCK_VALUE(16'h0001), .BACKOFF_CYCLES(BOFF), .MAX_RETRIES(MAXR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .acquire_req(acquire_req), .release_req(release_req),
    .busy(busy), .locked(locked), .acq_fail(acq_fail), .mtx_address(mtx_address),
    .mtx_chipselect(mtx_chipselect), .mtx_read(mtx_read), .mtx_write(mtx_write),
    .mtx_writedata(mtx_writedata), .mtx_readdata(mtx_readdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Mutex slave: a write takes effect only if the mutex is free or already ours.
  // A competing owner holds it and lets go after contend_k read-backs.
  logic [31:0] mtx_reg = 32'h0;
  logic [31:0] load_val = 32'h0;
  int load_seq = 0, load_done = 0, rd_seen = 0, contend_k = 0;
  assign mtx_readdata = mtx_reg;

  always @(posedge clk) begin
    if (load_seq != load_done) begin
      mtx_reg   <= load_val;
      rd_seen   <= 0;
      load_done <= load_seq;
    end else begin
      if (mtx_chipselect && mtx_write && !mtx_address &&
          (mtx_reg[15:0] == 16'h0 || mtx_reg[31:16] == mtx_writedata[31:16]))
        mtx_reg <= mtx_writedata;
      if (mtx_chipselect && mtx_read) begin
        rd_seen <= rd_seen + 1;
        if (rd_seen + 1 == contend_k) mtx_reg <= 32'h0;
      end
    end
  end

  int          ncyc = 0, rd_tot = 0, fail_tot = 0;
  int          wr_t[$];
  logic [31:0] wr_d[$];
  logic        wr_a[$];

  always @(negedge clk) begin
    ncyc++;
    if (reset_n) begin
      if (mtx_chipselect && mtx_write) begin
        wr_t.push_back(ncyc);
        wr_d.push_back(mtx_writedata);
        wr_a.push_back(mtx_address);
      end
      if (mtx_chipselect && mtx_read) rd_tot++;
      if (acq_fail) fail_tot++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_mutex(input logic [31:0] v, input int k);
    load_val  = v;
    contend_k = k;
    load_seq++;
    step();
    step();
  endtask

  // k = failed attempts before the competing owner lets go; k >= MAXR means the attempt budget runs out.
  task automatic do_acquire(input int k);
    int n0, wb, rb, fb, t, nexp;
    bit got_lock, got_fail;
    set_mutex((k == 0) ? 32'h0 : OTHER_WORD, k);
    n0 = ncyc; wb = wr_t.size(); rb = rd_tot; fb = fail_tot;
    acquire_req = 1'b1;
    got_lock = 0; got_fail = 0; t = 0;
    for (int i = 0; i < 100 && !got_lock && !got_fail; i++) begin
      step();
      if (locked) begin
        got_lock = 1; t = ncyc - n0;
      end else if (acq_fail) begin
        got_fail = 1; t = ncyc - n0; acquire_req = 1'b0;
      end
    end
    if (k < MAXR) begin
      nexp = k + 1;
      chk("acq_locked", 32'(got_lock), 1);
      chk("acq_lock_time", t, 3 + ATTEMPT * k);
      chk("acq_busy", 32'(busy), 0);
    end else begin
      nexp = MAXR;
      acquire_req = 1'b0;
      chk("acq_failed", 32'(got_fail), 1);
      chk("acq_fail_time", t, 3 + ATTEMPT * (MAXR - 1));
      repeat (3) step();
      chk("fail_locked", 32'(locked), 0);
      chk("fail_busy", 32'(busy), 0);
    end
    chk("acq_fail_cnt", fail_tot - fb, (k < MAXR) ? 0 : 1);
    chk("acq_wr_n", wr_t.size() - wb, nexp);
    chk("acq_rd_n", rd_tot - rb, nexp);
    for (int i = 0; i < nexp && wb + i < wr_t.size(); i++) begin
      chk("acq_wr_time", wr_t[wb+i] - n0, 1 + ATTEMPT * i);
      chk("acq_wr_data", wr_d[wb+i], {OWNER, 16'h0001});
      chk("acq_wr_addr", 32'(wr_a[wb+i]), 0);
    end
  endtask

  // acquire_req is still high here, so the release cycle also exercises release-over-acquire priority.
  task automatic do_release(input int h);
    int m0, wb, rb;
    repeat (h) step();
    chk("hold_locked", 32'(locked), 1);
    m0 = ncyc; wb = wr_t.size(); rb = rd_tot;
    release_req = 1'b1;
    step();
    release_req = 1'b0;
    acquire_req = 1'b0;
    chk("rel_locked", 32'(locked), 0);
    chk("rel_busy", 32'(busy), 1);
    step();
    step();
    chk("rel_wr_n", wr_t.size() - wb, 1);
    if (wr_t.size() > wb) begin
      chk("rel_wr_time", wr_t[wb] - m0, 1);
      chk("rel_wr_data", wr_d[wb], {OWNER, 16'h0000});
      chk("rel_wr_addr", 32'(wr_a[wb]), 0);
    end
    chk("rel_rd_n", rd_tot - rb, 0);
    chk("rel_idle_busy", 32'(busy), 0);
  endtask

  function automatic logic [6:0] outs();
    return {busy, locked, acq_fail, mtx_address, mtx_chipselect, mtx_read, mtx_write};
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n0, wb, fb, d, r, k;
    repeat (3) step();
    chk("rst_outs", 32'(outs()), 0);
    chk("rst_wdata", mtx_writedata, 32'h0);
    reset_n = 1'b1;
    step();

    do_acquire(0);
    do_release(2);
    do_acquire(MAXR);
    do_acquire(2);
    do_release(0);

    // Drop the request inside the first backoff window: the engine must abort quietly.
    set_mutex(OTHER_WORD, 99);
    n0 = ncyc; wb = wr_t.size(); fb = fail_tot;
    acquire_req = 1'b1;
    d = $urandom_range(3, 2 + BOFF);
    repeat (d) step();
    acquire_req = 1'b0;
    while (ncyc < n0 + 3 + BOFF) step();
    chk("abort_busy", 32'(busy), 0);
    repeat (15) step();
    chk("abort_wr_n", wr_t.size() - wb, 1);
    chk("abort_fail", fail_tot - fb, 0);
    chk("abort_locked", 32'(locked), 0);

    // Async reset mid-backoff, then both requests high on release of reset.
    set_mutex(OTHER_WORD, 99);
    n0 = ncyc;
    acquire_req = 1'b1;
    repeat (5) step();
    chk("pre_rst_busy", 32'(busy), 1);
    reset_n = 1'b0;
    #1;
    chk("midrst_outs", 32'(outs()), 0);
    chk("midrst_wdata", mtx_writedata, 32'h0);
    release_req = 1'b1;
    set_mutex(32'h0, 0);
    chk("held_rst_outs", 32'(outs()), 0);
    r = ncyc; wb = wr_t.size();
    reset_n = 1'b1;
    step();
    release_req = 1'b0;
    step();
    step();
    chk("postrst_locked", 32'(locked), 1);
    chk("postrst_wr_n", wr_t.size() - wb, 1);
    if (wr_t.size() > wb) begin
      chk("postrst_wr_time", wr_t[wb] - r, 1);
      chk("postrst_wr_data", wr_d[wb], {OWNER, 16'h0001});
    end
    do_release(1);

    for (int i = 0; i < 10; i++) begin
      k = $urandom_range(0, MAXR + 1);
      do_acquire(k);
      if (k < MAXR) do_release($urandom_range(0, 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
